// File: rtl/encoder16to4_serial.sv
// Sequential 16->4 encoder: loads a request vector, then emits the index of each set bit, one per handshake.
// Define ENCODER_MSB_FIRST_EN to give the highest set index priority (descending emission order).
module encoder16to4_serial (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in,
    output logic        in_ready,
    output logic        out_valid,
    output logic [3:0]  out,
    output logic        last,
    input  logic        out_ready
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_n_s;
    logic [15:0] pending_r;
    logic [15:0] pending_n_s;
    logic [3:0]  out_r;
    logic        last_r;
    logic        out_valid_r;
    logic        in_ready_r;

    // Index of the priority bit of a vector; zero when the vector is empty.
    function automatic logic [3:0] prio_idx(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
`ifdef ENCODER_MSB_FIRST_EN
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                idx = i[3:0];
            end else begin
                idx = idx;
            end
        end
`else
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = i[3:0];
            end else begin
                idx = idx;
            end
        end
`endif
        return idx;
    endfunction

    // True when exactly one bit of the vector is set.
    function automatic logic one_hot(input logic [15:0] v);
        return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
    endfunction

    // Next-state and next-pending decision for load and handshake.
    always_comb begin
        state_n_s   = state_r;
        pending_n_s = pending_r;
        case (state_r)
            IDLE: begin
                if (in_valid && (in != 16'd0)) begin
                    pending_n_s = in;
                    state_n_s   = SCAN;
                end else begin
                    pending_n_s = pending_r;
                    state_n_s   = IDLE;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    pending_n_s = pending_r & ~(16'd1 << out_r);
                    if (last_r) begin
                        state_n_s = IDLE;
                    end else begin
                        state_n_s = SCAN;
                    end
                end else begin
                    pending_n_s = pending_r;
                    state_n_s   = SCAN;
                end
            end
            default: begin
                pending_n_s = 16'd0;
                state_n_s   = IDLE;
            end
        endcase
    end

    // State, pending vector and the outputs decoded from the next pending value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            pending_r   <= 16'd0;
            out_r       <= 4'd0;
            last_r      <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_n_s;
            pending_r   <= pending_n_s;
            out_r       <= prio_idx(pending_n_s);
            last_r      <= one_hot(pending_n_s);
            out_valid_r <= (state_n_s == SCAN);
            in_ready_r  <= (state_n_s == IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out       = out_r;
    assign last      = last_r;

endmodule

// File: tb/tb_encoder16to4_serial.sv
// Randomized bench for encoder16to4_serial with a queue-based reference model plus directed literal checks.
// Build with ENCODER_MSB_FIRST_EN defined to check descending priority.
module tb_encoder16to4_serial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in = 16'd0;
    logic        in_ready;
    logic        out_valid;
    logic [3:0]  out;
    logic        last;
    logic        out_ready = 1'b0;

    int checks = 0;
    int passes = 0;
    int exp_q[$];

    encoder16to4_serial dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in),
        .in_ready(in_ready), .out_valid(out_valid), .out(out),
        .last(last), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Expected emission list for a vector, straight from the priority rule.
    function automatic void load_model(input logic [15:0] v);
        exp_q.delete();
`ifdef ENCODER_MSB_FIRST_EN
        for (int i = 15; i >= 0; i--) if (v[i]) exp_q.push_back(i);
`else
        for (int i = 0; i < 16; i++) if (v[i]) exp_q.push_back(i);
`endif
    endfunction

    // Model update: pop on handshake, load on accepted nonzero vector.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_q.delete();
        else if (exp_q.size() > 0) begin
            if (out_ready) void'(exp_q.pop_front());
        end else if (in_valid && in != 16'd0) load_model(in);
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("in_ready", in_ready, exp_q.size() == 0);
        chk("out_valid", out_valid, exp_q.size() > 0);
        chk("out", {28'd0, out}, (exp_q.size() > 0) ? exp_q[0] : 0);
        chk("last", last, exp_q.size() == 1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int ord[4];
    int bp0, bp1, busy0, busy1;
    bit done;

    initial begin
`ifdef ENCODER_MSB_FIRST_EN
        ord = '{15, 10, 5, 0};
        bp0 = 1; bp1 = 0; busy0 = 9; busy1 = 8;
`else
        ord = '{0, 5, 10, 15};
        bp0 = 0; bp1 = 1; busy0 = 8; busy1 = 9;
`endif
        // reset state, with an offer that must be ignored
        in_valid = 1'b1; in = 16'h0101;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1); chk("rst_out_valid", out_valid, 0);
        chk("rst_out", {28'd0, out}, 0); chk("rst_last", last, 0);
        in_valid = 1'b0;
        step(); rst_n = 1'b1;
        step();

        // single bit
        in = 16'h0001; in_valid = 1'b1; out_ready = 1'b1;
        step(); in_valid = 1'b0;
        @(negedge clk);
        chk("single_out", {28'd0, out}, 0); chk("single_valid", out_valid, 1); chk("single_last", last, 1);
        step();
        @(negedge clk);
        chk("single_idle_valid", out_valid, 0); chk("single_idle_ready", in_ready, 1);

        // multi-bit order
        step(); in = 16'h8421; in_valid = 1'b1;
        step(); in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("order_out", {28'd0, out}, ord[k]); chk("order_last", last, k == 3);
            step();
        end
        @(negedge clk); chk("order_idle", in_ready, 1);

        // backpressure
        step(); in = 16'h0003; in_valid = 1'b1; out_ready = 1'b0;
        step(); in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_hold_out", {28'd0, out}, bp0); chk("bp_hold_last", last, 0);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk); chk("bp_first", {28'd0, out}, bp0);
        step();
        @(negedge clk); chk("bp_second", {28'd0, out}, bp1); chk("bp_second_last", last, 1);
        step();
        @(negedge clk); chk("bp_idle", in_ready, 1);

        // zero vector, then offer during busy
        in = 16'h0000; in_valid = 1'b1;
        step(); step();
        @(negedge clk); chk("zero_valid", out_valid, 0); chk("zero_ready", in_ready, 1);
        in = 16'h0300;
        step(); in = 16'h0001;
        @(negedge clk); chk("busy_first", {28'd0, out}, busy0);
        step();
        @(negedge clk); chk("busy_second", {28'd0, out}, busy1); chk("busy_last", last, 1);
        step(); in_valid = 1'b0;
        @(negedge clk); chk("busy_idle", out_valid, 0);
        step();

        // full vector
        in = 16'hFFFF; in_valid = 1'b1;
        step(); in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
`ifdef ENCODER_MSB_FIRST_EN
            chk("full_out", {28'd0, out}, 15 - k);
`else
            chk("full_out", {28'd0, out}, k);
`endif
            chk("full_last", last, k == 15);
            step();
        end
        @(negedge clk); chk("full_ready17", in_ready, 1);

        // async reset mid-scan
        step(); in = 16'h00F0; in_valid = 1'b1; out_ready = 1'b0;
        step(); in_valid = 1'b0; step();
        @(negedge clk); chk("pre_rst_valid", out_valid, 1);
        #2; rst_n = 1'b0; #1;
        chk("arst_valid", out_valid, 0); chk("arst_ready", in_ready, 1);
        chk("arst_out", {28'd0, out}, 0); chk("arst_last", last, 0);
        in = 16'h00FF; in_valid = 1'b1;
        step(); step(); in_valid = 1'b0; out_ready = 1'b1;
        rst_n = 1'b1;
        repeat (3) step();

        // randomized traffic with occasional async resets
        for (int c = 0; c < 3000; c++) begin
            int kind;
            kind = $urandom_range(0, 7);
            in_valid = ($urandom_range(0, 2) == 0);
            in = (kind == 0) ? 16'h0000 : (kind == 1) ? 16'hFFFF : 16'($urandom & $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0; #2; rst_n = 1'b1;
            end
            step();
        end

        // bounded drain
        in_valid = 1'b0; out_ready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            step();
            if (in_ready) done = 1'b1;
        end
        chk("drain_timeout", done, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/encoder16to4_serial.md
# encoder16to4_serial

Sequential 16→4 encoder, the inverse end of the team's 4→16 one-hot decoder. Accepts a 16-bit request vector (any number of bits set), then emits the 4-bit index of every set bit, one per handshake, in fixed priority order. Sits between a bit-vector producer (interrupt/request flags) and any consumer of binary indices, e.g. one feeding a 4→16 decoder.

## Interface
- No parameters; widths fixed at 16 in, 4 out.
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  producer offers a vector on `in`
- in  in  16  request vector, bit i = request i
- in_ready  out  1  block can accept a vector (high only in IDLE)
- out_valid  out  1  `out` holds a valid index
- out  out  4  binary index of the current highest-priority pending bit
- last  out  1  high with `out_valid` when `out` is the final pending bit of the vector
- out_ready  in  1  consumer accepts `out`

## Operation
- Internal state: 16-bit `pending` register and a two-state FSM: IDLE, SCAN.
- IDLE: in_ready=1, out_valid=0. On edge with in_valid=1:
  - in≠0: pending←in, go to SCAN.
  - in=0: vector discarded, stay IDLE, no output produced.
- SCAN: in_ready=0, out_valid=1; in_valid and `in` ignored.
  - `out` = index of priority bit of `pending` (lowest set index by default, see Configuration); combinational decode of the registered `pending`.
  - `last` = 1 when `pending` has exactly one bit set.
  - On edge with out_ready=1: clear that bit in `pending`; if it was the last bit, go to IDLE.
  - out_ready=0: `pending`, `out`, `last` hold unchanged.
- `out`=4'b0000 and last=0 whenever pending=0.
- Number of outputs per vector = popcount(in), 1..16.

## Timing
- Reset (rst_n low, asynchronous, takes effect without a clock): pending=0, FSM=IDLE → in_ready=1, out_valid=0, out=0, last=0. Vector offers ignored while rst_n low.
- Reset mid-SCAN: remaining indices lost, outputs return to reset values immediately.
- Load latency: vector accepted on edge N → first index valid after edge N (cycle N+1).
- Throughput: one index per cycle with out_ready held high.
- Last handshake at edge M → in_ready=1 from cycle M+1; new vector earliest accepted at edge M+1. No load/emit overlap; vector of k bits occupies k+1 cycles minimum from accept to next accept.
- out_valid never drops without a handshake or reset; `out` stable while out_valid=1 and out_ready=0.
- Input vector 16'hFFFF: indices emitted for all 16 bits, including index 15 (4'b1111); no wrap or overflow.

## Configuration
- Macro `ENCODER_MSB_FIRST_EN`.
- Undefined (default): lowest set index has priority; indices emitted ascending.
- Defined: highest set index has priority; indices emitted descending. `last` rule, handshake and timing unchanged.

## Test plan
- Reset: drive rst_n=0 during SCAN of 16'h00F0 → same cycle out_valid=0, in_ready=1, out=0, last=0; after release no stale indices emitted.
- Single bit: in=16'h0001, in_valid=1 one cycle, out_ready=1 → next cycle out=0, out_valid=1, last=1; following cycle out_valid=0, in_ready=1.
- Multi-bit order: in=16'h8421, out_ready=1 → out=0,5,10,15 on 4 consecutive cycles, last only with 15; with `ENCODER_MSB_FIRST_EN` → 15,10,5,0, last with 0.
- Backpressure: in=16'h0003, out_ready=0 for 3 cycles → out=0, last=0 held; out_ready=1 → out=1, last=1, then IDLE.
- Zero and busy inputs: in=0 with in_valid=1 → no out_valid, in_ready stays 1; during SCAN of 16'h0300 offer 16'h0001 → ignored, only 8,9 emitted.
- Full vector: in=16'hFFFF, out_ready=1 → indices 0..15 on 16 consecutive cycles, last with 15, in_ready=1 on cycle 17.
